// File: rtl/hmac_sha256_ctrl_pkg.sv
// Shared constants, state encoding and padding helper for the HMAC-SHA256 sequencer.
package hmac_sha256_ctrl_pkg;

    localparam int DEF_BLOCK_W  = 512;
    localparam int DEF_DIGEST_W = 256;
    localparam int DEF_CNT_W    = 32;

    localparam logic [7:0] IPAD_BYTE = 8'h36;
    localparam logic [7:0] OPAD_BYTE = 8'h5c;

    // Outer hash input is one 64-byte key block plus the 32-byte inner digest.
    localparam int OUTER_LEN_BITS = 768;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IKEY,
        ST_IMSG_WAIT,
        ST_IMSG_RUN,
        ST_OKEY,
        ST_OFIN,
        ST_DONE
    } hmac_state_e;

    // Final outer block: inner digest, 0x80 terminator, zero fill, 64-bit length.
    function automatic logic [511:0] outer_final_block(input logic [255:0] inner);
        return {inner, 8'h80, 184'd0, 64'(OUTER_LEN_BITS)};
    endfunction

endpackage

// File: rtl/hmac_sha256_ctrl_if.sv
// Request, message, MAC and compression-core signals of the HMAC-SHA256 sequencer.
interface hmac_sha256_ctrl_if #(
    parameter int BLOCK_W  = hmac_sha256_ctrl_pkg::DEF_BLOCK_W,
    parameter int DIGEST_W = hmac_sha256_ctrl_pkg::DEF_DIGEST_W,
    parameter int CNT_W    = hmac_sha256_ctrl_pkg::DEF_CNT_W
);
    logic                start;
    logic [BLOCK_W-1:0]  key;
    logic                abort;

    logic                msg_valid;
    logic                msg_ready;
    logic [BLOCK_W-1:0]  msg_block;
    logic                msg_last;

    logic                core_start;
    logic [BLOCK_W-1:0]  core_block;
    logic [DIGEST_W-1:0] core_cv;
    logic                core_done;
    logic [DIGEST_W-1:0] core_digest;

    logic                mac_valid;
    logic                mac_ready;
    logic [DIGEST_W-1:0] mac;

    logic                busy;
    logic [CNT_W-1:0]    blk_cnt;

    // Controller side.
    modport slave (
        input  start, key, abort,
        input  msg_valid, msg_block, msg_last,
        input  core_done, core_digest,
        input  mac_ready,
        output msg_ready,
        output core_start, core_block, core_cv,
        output mac_valid, mac,
        output busy, blk_cnt
    );

    // Requester / core-model side.
    modport master (
        output start, key, abort,
        output msg_valid, msg_block, msg_last,
        output core_done, core_digest,
        output mac_ready,
        input  msg_ready,
        input  core_start, core_block, core_cv,
        input  mac_valid, mac,
        input  busy, blk_cnt
    );

endinterface

// File: rtl/hmac_sha256_ctrl.sv
// HMAC-SHA256 sequencer: drives one shared SHA-256 compression core through the inner and
// outer hashes and owns the key, chaining value and inner digest storage.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | waiting for start
// ST_IKEY      | compressing key ^ ipad from the IV
// ST_IMSG_WAIT | msg_ready high, waiting for a message block
// ST_IMSG_RUN  | compressing the accepted message block
// ST_OKEY      | compressing key ^ opad from the IV
// ST_OFIN      | compressing the padded inner digest
// ST_DONE      | mac_valid high until mac_ready
module hmac_sha256_ctrl
    import hmac_sha256_ctrl_pkg::*;
#(
    parameter int BLOCK_W  = DEF_BLOCK_W,
    parameter int DIGEST_W = DEF_DIGEST_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    hmac_sha256_ctrl_if.slave bus
);

    localparam logic [BLOCK_W-1:0] IPAD_BLOCK = {(BLOCK_W/8){IPAD_BYTE}};
    localparam logic [BLOCK_W-1:0] OPAD_BLOCK = {(BLOCK_W/8){OPAD_BYTE}};

    hmac_state_e         state;
    logic [BLOCK_W-1:0]  key_r;
    logic [DIGEST_W-1:0] cv_r;
    logic [DIGEST_W-1:0] inner_r;
    logic                last_r;
    logic                core_start_r;
    logic [BLOCK_W-1:0]  core_block_r;
    logic [DIGEST_W-1:0] core_cv_r;
    logic                msg_ready_r;
    logic                mac_valid_r;
    logic [DIGEST_W-1:0] mac_r;
    logic                busy_r;
    logic [CNT_W-1:0]    blk_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            key_r        <= '0;
            cv_r         <= '0;
            inner_r      <= '0;
            last_r       <= 1'b0;
            core_start_r <= 1'b0;
            core_block_r <= '0;
            core_cv_r    <= '0;
            msg_ready_r  <= 1'b0;
            mac_valid_r  <= 1'b0;
            mac_r        <= '0;
            busy_r       <= 1'b0;
            blk_cnt_r    <= '0;
        end else begin
            core_start_r <= 1'b0;
            // Abort beats start and core_done; a compression still in flight finishes
            // in the core and its core_done lands in IDLE where it is ignored.
            if (bus.abort) begin
                state       <= ST_IDLE;
                msg_ready_r <= 1'b0;
                mac_valid_r <= 1'b0;
                busy_r      <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            key_r        <= bus.key;
                            blk_cnt_r    <= '0;
                            core_block_r <= bus.key ^ IPAD_BLOCK;
                            core_cv_r    <= SHA256_IV;
                            core_start_r <= 1'b1;
                            busy_r       <= 1'b1;
                            state        <= ST_IKEY;
                        end
                    end
                    ST_IKEY: begin
                        if (bus.core_done) begin
                            cv_r        <= bus.core_digest;
                            msg_ready_r <= 1'b1;
                            state       <= ST_IMSG_WAIT;
                        end
                    end
                    ST_IMSG_WAIT: begin
                        if (bus.msg_valid && msg_ready_r) begin
                            last_r       <= bus.msg_last;
                            core_block_r <= bus.msg_block;
                            core_cv_r    <= cv_r;
                            core_start_r <= 1'b1;
                            msg_ready_r  <= 1'b0;
                            state        <= ST_IMSG_RUN;
                        end
                    end
                    ST_IMSG_RUN: begin
                        if (bus.core_done) begin
                            cv_r      <= bus.core_digest;
                            blk_cnt_r <= blk_cnt_r + CNT_W'(1);
                            if (last_r) begin
                                inner_r      <= bus.core_digest;
                                core_block_r <= key_r ^ OPAD_BLOCK;
                                core_cv_r    <= SHA256_IV;
                                core_start_r <= 1'b1;
                                state        <= ST_OKEY;
                            end else begin
                                msg_ready_r <= 1'b1;
                                state       <= ST_IMSG_WAIT;
                            end
                        end
                    end
                    ST_OKEY: begin
                        if (bus.core_done) begin
                            cv_r         <= bus.core_digest;
                            core_block_r <= outer_final_block(inner_r);
                            core_cv_r    <= bus.core_digest;
                            core_start_r <= 1'b1;
                            state        <= ST_OFIN;
                        end
                    end
                    ST_OFIN: begin
                        if (bus.core_done) begin
                            mac_r       <= bus.core_digest;
                            mac_valid_r <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (bus.mac_ready) begin
                            mac_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                    default: begin
                        msg_ready_r <= 1'b0;
                        mac_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.msg_ready  = msg_ready_r;
    assign bus.core_start = core_start_r;
    assign bus.core_block = core_block_r;
    assign bus.core_cv    = core_cv_r;
    assign bus.mac_valid  = mac_valid_r;
    assign bus.mac        = mac_r;
    assign bus.busy       = busy_r;
    assign bus.blk_cnt    = blk_cnt_r;

endmodule

// File: tb/tb_hmac_sha256_ctrl.sv
// Bench for hmac_sha256_ctrl: behavioural SHA-256 core with variable latency, RFC4231 tc2 and
// reference-model HMAC checks, abort, reset and back-pressure cases.
module tb_hmac_sha256_ctrl;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [511:0] TC2_KEY = {32'h4a656665, 480'd0};
    localparam logic [511:0] TC2_BLK = {224'h7768617420646f2079612077616e7420666f72206e6f7468696e673f,
                                        8'h80, 216'd0, 64'h2e0};
    localparam logic [255:0] TC2_MAC = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hmac_sha256_ctrl_if bus ();

    hmac_sha256_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] cv, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = cv;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {cv[255:224] + a, cv[223:192] + b, cv[191:160] + c, cv[159:128] + d,
                cv[127:96]  + e, cv[95:64]    + f, cv[63:32]    + g, cv[31:0]     + h};
    endfunction

    logic [511:0] msgs [8];

    function automatic logic [255:0] hmac_ref(input logic [511:0] k, input int n);
        logic [255:0] ih, oh;
        ih = sha_compress(IV, k ^ {64{8'h36}});
        for (int i = 0; i < n; i++) ih = sha_compress(ih, msgs[i]);
        oh = sha_compress(IV, k ^ {64{8'h5c}});
        return sha_compress(oh, {ih, 8'h80, 184'd0, 64'd768});
    endfunction

    // Behavioural compression core: latency in cycles drawn from [lat_lo, lat_hi].
    int           lat_lo = 1;
    int           lat_hi = 1;
    int           starts = 0;
    int           cnt    = 0;
    logic         pend   = 1'b0;
    logic [255:0] res;

    always @(negedge clk) begin
        bus.core_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    bus.core_done   = 1'b1;
                    bus.core_digest = res;
                    pend            = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (bus.core_start) begin
                chk("core_overlap", 256'(pend), 256'd0);
                starts++;
                res  = sha_compress(bus.core_cv, bus.core_block);
                cnt  = int'($urandom_range(lat_hi, lat_lo));
                pend = 1'b1;
            end
        end
    end

    task automatic pulse_start(input logic [511:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [511:0] blk, input logic last, input int gap);
        int w = 0;
        repeat (gap) @(negedge clk);
        bus.msg_block = blk;
        bus.msg_last  = last;
        bus.msg_valid = 1'b1;
        while (!bus.msg_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("msg_accept_tmo", 256'(w >= 3000), 256'd0);
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    task automatic wait_mac(input string tag);
        int w = 0;
        while (!bus.mac_valid && w < 6000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_mac_tmo"}, 256'(w >= 6000), 256'd0);
    endtask

    task automatic wait_starts(input int target);
        int w = 0;
        #1;
        while (starts < target && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("start_wait_tmo", 256'(w >= 3000), 256'd0);
    endtask

    task automatic accept_mac(input string tag);
        bus.mac_ready = 1'b1;
        @(negedge clk);
        bus.mac_ready = 1'b0;
        chk({tag, "_mv_drop"}, 256'(bus.mac_valid), 256'd0);
        chk({tag, "_idle"}, 256'(bus.busy), 256'd0);
    endtask

    task automatic run_mac(input string tag, input logic [511:0] k, input int n, input int gap_max,
                           input logic [255:0] exp);
        int s0 = starts;
        pulse_start(k);
        for (int i = 0; i < n; i++) feed(msgs[i], (i == n - 1), int'($urandom_range(gap_max, 0)));
        wait_mac(tag);
        chk({tag, "_mac"}, bus.mac, exp);
        chk({tag, "_starts"}, 256'(starts - s0), 256'(n + 3));
        chk({tag, "_blk_cnt"}, 256'(bus.blk_cnt), 256'(n));
        accept_mac(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [511:0] k;
        logic [255:0] exp;
        int           s0;
        int           n;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.key       = '0;
        bus.abort     = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_block = '0;
        bus.msg_last  = 1'b0;
        bus.mac_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_msg_ready", 256'(bus.msg_ready), 256'd0);
        chk("rst_mac_valid", 256'(bus.mac_valid), 256'd0);
        chk("rst_core_start", 256'(bus.core_start), 256'd0);
        chk("rst_mac", bus.mac, 256'd0);
        chk("rst_blk_cnt", 256'(bus.blk_cnt), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort and start in the same IDLE cycle: abort wins
        bus.key   = TC2_KEY;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_busy", 256'(bus.busy), 256'd0);
        chk("abort_start_core_start", 256'(bus.core_start), 256'd0);
        @(negedge clk);

        // RFC4231 test case 2
        msgs[0] = TC2_BLK;
        run_mac("tc2", TC2_KEY, 1, 0, TC2_MAC);

        // three blocks with msg_valid gaps and variable latency
        for (int j = 0; j < 16; j++) k[j*32 +: 32] = $urandom();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 16; j++) msgs[i][j*32 +: 32] = $urandom();
        lat_lo = 1;
        lat_hi = 8;
        exp = hmac_ref(k, 3);
        run_mac("three_blk", k, 3, 5, exp);

        // back-pressure on the MAC, with start pulses while DONE
        lat_hi  = 1;
        msgs[0] = TC2_BLK;
        pulse_start(TC2_KEY);
        feed(msgs[0], 1'b1, 0);
        wait_mac("hold");
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 3);
            chk("hold_mac_valid", 256'(bus.mac_valid), 256'd1);
            chk("hold_mac", bus.mac, TC2_MAC);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("hold_no_restart", 256'(starts - s0), 256'd0);
        accept_mac("hold");
        repeat (3) @(negedge clk);
        chk("hold_stays_idle", 256'(bus.busy), 256'd0);
        chk("hold_no_late_start", 256'(starts - s0), 256'd0);

        // abort during IMSG_RUN; core_done arrives two cycles after the abort
        lat_lo = 2;
        lat_hi = 2;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) msgs[i][j*32 +: 32] = $urandom();
        s0 = starts;
        pulse_start(TC2_KEY);
        feed(msgs[0], 1'b0, 0);
        wait_starts(s0 + 2);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_busy", 256'(bus.busy), 256'd0);
        chk("abort_mac_valid", 256'(bus.mac_valid), 256'd0);
        chk("abort_msg_ready", 256'(bus.msg_ready), 256'd0);
        chk("abort_no_more_starts", 256'(starts - s0), 256'd2);
        lat_lo  = 1;
        lat_hi  = 4;
        msgs[0] = TC2_BLK;
        run_mac("after_abort", TC2_KEY, 1, 2, TC2_MAC);

        // reset asserted in OKEY, in the cycle core_start is high
        lat_lo = 10;
        lat_hi = 10;
        s0 = starts;
        pulse_start(TC2_KEY);
        feed(msgs[0], 1'b1, 0);
        wait_starts(s0 + 3);
        chk("okey_core_start_seen", 256'(bus.core_start), 256'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_core_start", 256'(bus.core_start), 256'd0);
        chk("mid_rst_busy", 256'(bus.busy), 256'd0);
        chk("mid_rst_mac_valid", 256'(bus.mac_valid), 256'd0);
        chk("mid_rst_msg_ready", 256'(bus.msg_ready), 256'd0);
        chk("mid_rst_blk_cnt", 256'(bus.blk_cnt), 256'd0);
        chk("mid_rst_mac", bus.mac, 256'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        lat_lo = 1;
        lat_hi = 3;
        @(negedge clk);
        run_mac("tc2_after_rst", TC2_KEY, 1, 1, TC2_MAC);

        // random keys and messages against the reference model
        lat_lo = 1;
        lat_hi = 64;
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(8, 1));
            for (int j = 0; j < 16; j++) k[j*32 +: 32] = $urandom();
            for (int i = 0; i < n; i++)
                for (int j = 0; j < 16; j++) msgs[i][j*32 +: 32] = $urandom();
            exp = hmac_ref(k, n);
            run_mac("rand", k, n, 3, exp);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
